// File: rtl/game_pkg.sv
// Shared encodings and widths for the level controller and its helpers.
package game_pkg;

    localparam int unsigned LEVEL_W       = 4;
    localparam int unsigned TIME_W        = 11;
    localparam int unsigned PAUSE_W       = 8;
    localparam int unsigned MAX_LEVEL_DEF = 9;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StPlay  = 3'd1,
        StPause = 3'd2,
        StWin   = 3'd3,
        StLose  = 3'd4
    } game_state_e;

endpackage

// File: rtl/vsync_edge.sv
// Rising-edge detector on v_sync_in; frame_tick is a registered one-cycle pulse.
module vsync_edge (
    input  logic clk,
    input  logic rst,
    input  logic v_sync_in,
    output logic frame_tick
);

    logic vs_prev_q;
    logic tick_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_prev_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            vs_prev_q <= v_sync_in;
            tick_q    <= v_sync_in & ~vs_prev_q;
        end
    end

    assign frame_tick = tick_q;

endmodule

// File: rtl/game_level_ctrl.sv
// Level sequencing FSM: per-level frame timer, inter-level pause, win/lose handling.
module game_level_ctrl
    import game_pkg::*;
#(
    parameter int unsigned FRAME_LIMIT  = 1800,
    parameter int unsigned PAUSE_FRAMES = 120,
    parameter int unsigned MAX_LEVEL    = MAX_LEVEL_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               v_sync_in,
    input  logic               start,
    input  logic               level_done,
    input  logic               fail,
    output logic [LEVEL_W-1:0] level,
    output logic [TIME_W-1:0]  time_left,
    output logic               playing,
    output logic               frame_tick,
    output logic               game_over,
    output logic               game_won
);

    localparam logic [TIME_W-1:0]  FrameLimit  = TIME_W'(FRAME_LIMIT);
    localparam logic [PAUSE_W-1:0] PauseFrames = PAUSE_W'(PAUSE_FRAMES);
    localparam logic [LEVEL_W-1:0] MaxLevel    = LEVEL_W'(MAX_LEVEL);
    localparam logic [LEVEL_W-1:0] FirstLevel  = LEVEL_W'(1);

    game_state_e        state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [TIME_W-1:0]  time_q, time_d;
    logic [PAUSE_W-1:0] pause_q, pause_d;
    logic               playing_q, game_over_q, game_won_q;
    logic               tick;

    vsync_edge u_vsync_edge (
        .clk        (clk),
        .rst        (rst),
        .v_sync_in  (v_sync_in),
        .frame_tick (tick)
    );

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        time_d  = time_q;
        pause_d = pause_q;
        case (state_q)
            StIdle: begin
                level_d = FirstLevel;
                time_d  = FrameLimit;
                pause_d = '0;
                if (start) begin
                    state_d = StPlay;
                end
            end
            StPlay: begin
                // fail outranks level_done, which outranks the frame countdown
                if (fail) begin
                    state_d = StLose;
                end else if (level_done) begin
                    if (level_q < MaxLevel) begin
                        state_d = StPause;
                        level_d = level_q + FirstLevel;
                        pause_d = PauseFrames;
                    end else begin
                        state_d = StWin;
                    end
                end else if (tick) begin
                    if (time_q <= TIME_W'(1)) begin
                        time_d  = '0;
                        state_d = StLose;
                    end else begin
                        time_d = time_q - TIME_W'(1);
                    end
                end
            end
            StPause: begin
                if (pause_q == '0) begin
                    state_d = StPlay;
                    time_d  = FrameLimit;
                end else if (tick) begin
                    if (pause_q == PAUSE_W'(1)) begin
                        pause_d = '0;
                        state_d = StPlay;
                        time_d  = FrameLimit;
                    end else begin
                        pause_d = pause_q - PAUSE_W'(1);
                    end
                end
            end
            StWin, StLose: begin
                if (start) begin
                    state_d = StPlay;
                    level_d = FirstLevel;
                    time_d  = FrameLimit;
                end
            end
            default: begin
                state_d = StIdle;
                level_d = FirstLevel;
                time_d  = FrameLimit;
                pause_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            level_q     <= FirstLevel;
            time_q      <= FrameLimit;
            pause_q     <= '0;
            playing_q   <= 1'b0;
            game_over_q <= 1'b0;
            game_won_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            time_q      <= time_d;
            pause_q     <= pause_d;
            playing_q   <= (state_d == StPlay);
            game_over_q <= (state_d == StLose);
            game_won_q  <= (state_d == StWin);
        end
    end

    assign level      = level_q;
    assign time_left  = time_q;
    assign playing    = playing_q;
    assign frame_tick = tick;
    assign game_over  = game_over_q;
    assign game_won   = game_won_q;

endmodule

// File: tb/tb_game_level_ctrl.sv
// Directed-vector bench for game_level_ctrl with FRAME_LIMIT=10, PAUSE_FRAMES=3, MAX_LEVEL=9.
module tb_game_level_ctrl;

    logic        clk, rst, v_sync_in, start, level_done, fail;
    logic [3:0]  level;
    logic [10:0] time_left;
    logic        playing, frame_tick, game_over, game_won;
    int          checks = 0;
    int          errors = 0;

    game_level_ctrl #(
        .FRAME_LIMIT  (10),
        .PAUSE_FRAMES (3),
        .MAX_LEVEL    (9)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .v_sync_in  (v_sync_in),
        .start      (start),
        .level_done (level_done),
        .fail       (fail),
        .level      (level),
        .time_left  (time_left),
        .playing    (playing),
        .frame_tick (frame_tick),
        .game_over  (game_over),
        .game_won   (game_won)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One v_sync pulse; returns after the FSM has consumed the resulting tick.
    task automatic frame();
        @(negedge clk) v_sync_in = 1'b1;
        @(negedge clk) v_sync_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk) level_done = 1'b1;
        @(negedge clk) level_done = 1'b0;
    endtask

    task automatic advance_level();
        pulse_done();
        repeat (3) frame();
    endtask

    task automatic test_reset();
        rst = 1'b1; v_sync_in = 1'b0; start = 1'b0; level_done = 1'b0; fail = 1'b0;
        #1;
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL reset_level got %0d want 1", level); end
        checks++; if (time_left !== 11'd10) begin errors++; $display("FAIL reset_time got %0d want 10", time_left); end
        checks++; if ({playing, frame_tick, game_over, game_won} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {playing, frame_tick, game_over, game_won});
        end
        @(negedge clk) rst = 1'b0;
        pulse_done();
        @(negedge clk);
        checks++; if (playing !== 1'b0 || level !== 4'd1) begin
            errors++; $display("FAIL idle_ignores_done got playing=%b level=%0d want 0/1", playing, level);
        end
    endtask

    task automatic test_timeout();
        pulse_start();
        checks++; if (playing !== 1'b1 || level !== 4'd1 || time_left !== 11'd10) begin
            errors++; $display("FAIL start_play got p=%b l=%0d t=%0d want 1/1/10", playing, level, time_left);
        end
        repeat (9) frame();
        checks++; if (time_left !== 11'd1 || playing !== 1'b1) begin
            errors++; $display("FAIL nine_frames got t=%0d p=%b want 1/1", time_left, playing);
        end
        frame();
        checks++; if (game_over !== 1'b1 || time_left !== 11'd0 || playing !== 1'b0) begin
            errors++; $display("FAIL timeout got over=%b t=%0d p=%b want 1/0/0", game_over, time_left, playing);
        end
        frame();
        checks++; if (time_left !== 11'd0 || game_over !== 1'b1) begin
            errors++; $display("FAIL no_underflow got t=%0d over=%b want 0/1", time_left, game_over);
        end
    endtask

    task automatic test_level_up();
        pulse_start();
        checks++; if (playing !== 1'b1 || game_over !== 1'b0 || time_left !== 11'd10) begin
            errors++; $display("FAIL restart_lose got p=%b over=%b t=%0d want 1/0/10", playing, game_over, time_left);
        end
        repeat (2) frame();
        pulse_done();
        checks++; if (level !== 4'd2 || playing !== 1'b0 || time_left !== 11'd8) begin
            errors++; $display("FAIL enter_pause got l=%0d p=%b t=%0d want 2/0/8", level, playing, time_left);
        end
        @(negedge clk) fail = 1'b1;
        @(negedge clk) fail = 1'b0;
        pulse_start();
        checks++; if (game_over !== 1'b0 || playing !== 1'b0 || level !== 4'd2) begin
            errors++; $display("FAIL pause_ignores got over=%b p=%b l=%0d want 0/0/2", game_over, playing, level);
        end
        repeat (2) frame();
        checks++; if (playing !== 1'b0 || time_left !== 11'd8) begin
            errors++; $display("FAIL pause_two_ticks got p=%b t=%0d want 0/8", playing, time_left);
        end
        frame();
        checks++; if (playing !== 1'b1 || time_left !== 11'd10 || level !== 4'd2) begin
            errors++; $display("FAIL pause_exit got p=%b t=%0d l=%0d want 1/10/2", playing, time_left, level);
        end
    endtask

    task automatic test_win();
        repeat (7) advance_level();
        checks++; if (level !== 4'd9 || playing !== 1'b1) begin
            errors++; $display("FAIL reach_max got l=%0d p=%b want 9/1", level, playing);
        end
        pulse_done();
        checks++; if (game_won !== 1'b1 || level !== 4'd9 || playing !== 1'b0) begin
            errors++; $display("FAIL win got won=%b l=%0d p=%b want 1/9/0", game_won, level, playing);
        end
        pulse_start();
        checks++; if (level !== 4'd1 || playing !== 1'b1 || game_won !== 1'b0 || time_left !== 11'd10) begin
            errors++; $display("FAIL restart_win got l=%0d p=%b won=%b t=%0d want 1/1/0/10",
                               level, playing, game_won, time_left);
        end
    endtask

    task automatic test_priority();
        repeat (3) advance_level();
        checks++; if (level !== 4'd4 || playing !== 1'b1) begin
            errors++; $display("FAIL reach_four got l=%0d p=%b want 4/1", level, playing);
        end
        @(negedge clk) begin fail = 1'b1; level_done = 1'b1; end
        @(negedge clk) begin fail = 1'b0; level_done = 1'b0; end
        checks++; if (game_over !== 1'b1 || level !== 4'd4 || game_won !== 1'b0 || time_left !== 11'd10) begin
            errors++; $display("FAIL fail_over_done got over=%b l=%0d won=%b t=%0d want 1/4/0/10",
                               game_over, level, game_won, time_left);
        end
    endtask

    task automatic test_reset_mid_pause();
        pulse_start();
        repeat (3) advance_level();
        pulse_done();
        frame();
        checks++; if (level !== 4'd5 || playing !== 1'b0) begin
            errors++; $display("FAIL mid_pause got l=%0d p=%b want 5/0", level, playing);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (level !== 4'd1 || time_left !== 11'd10) begin
            errors++; $display("FAIL async_reset_vals got l=%0d t=%0d want 1/10", level, time_left);
        end
        checks++; if ({playing, frame_tick, game_over, game_won} !== 4'b0000) begin
            errors++; $display("FAIL async_reset_flags got %b want 0000", {playing, frame_tick, game_over, game_won});
        end
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        checks++; if (level !== 4'd1 || playing !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle got l=%0d p=%b want 1/0", level, playing);
        end
    endtask

    task automatic test_vsync_hold();
        int n = 0;
        pulse_start();
        @(negedge clk) v_sync_in = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (frame_tick) n++;
        end
        v_sync_in = 1'b0;
        checks++; if (n !== 1) begin errors++; $display("FAIL hold_ticks got %0d want 1", n); end
        checks++; if (time_left !== 11'd9) begin errors++; $display("FAIL hold_time got %0d want 9", time_left); end
        pulse_start();
        checks++; if (time_left !== 11'd9 || level !== 4'd1 || playing !== 1'b1) begin
            errors++; $display("FAIL play_ignores_start got t=%0d l=%0d p=%b want 9/1/1", time_left, level, playing);
        end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_level_up();
        test_win();
        test_priority();
        test_reset_mid_pause();
        test_vsync_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_level_ctrl.md
GAME_LEVEL_CTRL -- requirements
Module: game_level_ctrl

Interface
REQ-001 Parameter FRAME_LIMIT, default 1800: frames allowed per level (1..2047).
REQ-002 Parameter PAUSE_FRAMES, default 120: inter-level pause length in frames (1..255).
REQ-003 Parameter MAX_LEVEL, default 9: last level (1..15).
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  posedge clock, pixel clock domain.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 v_sync_in  in  1  vertical sync from the timing chain, active-high.
REQ-008 start  in  1  single-cycle start request from the button debouncer.
REQ-009 level_done  in  1  single-cycle pulse from game logic: level objective met.
REQ-010 fail  in  1  single-cycle pulse from game logic: player lost.
REQ-011 level  out  4  current level, 1..MAX_LEVEL, drives the background generator.
REQ-012 time_left  out  11  frames remaining in the current level.
REQ-013 playing  out  1  high only in PLAY.
REQ-014 frame_tick  out  1  one-cycle pulse per v_sync_in rising edge.
REQ-015 game_over  out  1  high only in LOSE.
REQ-016 game_won  out  1  high only in WIN.

Function
REQ-017 frame_tick SHALL assert the cycle after v_sync_in is sampled 1 having been sampled 0 on the previous cycle.
REQ-018 FSM states: IDLE, PLAY, PAUSE, WIN, LOSE; all outputs registered, updating on the same edge as the state register.
REQ-019 IDLE: level=1, time_left=FRAME_LIMIT; start -> PLAY.
REQ-020 PLAY: each frame_tick decrements time_left; on the tick where time_left is 1, time_left becomes 0 and state -> LOSE.
REQ-021 PLAY, level_done, level<MAX_LEVEL -> PAUSE, level increments on the same edge, pause counter loads PAUSE_FRAMES.
REQ-022 PLAY, level_done, level==MAX_LEVEL -> WIN, level held.
REQ-023 PLAY, fail -> LOSE, time_left held.
REQ-024 Priority in PLAY, same cycle: fail > level_done > timeout decrement.
REQ-025 PAUSE: time_left holds; each frame_tick decrements the pause counter; at 0 -> PLAY with time_left=FRAME_LIMIT.
REQ-026 level_done and fail SHALL be ignored in IDLE, PAUSE, WIN, LOSE.
REQ-027 WIN or LOSE: start -> PLAY with level=1, time_left=FRAME_LIMIT.
REQ-028 start SHALL be ignored in PLAY and PAUSE.
REQ-029 level SHALL never leave 1..MAX_LEVEL, and never wraps.
REQ-030 time_left SHALL never underflow below 0.
REQ-031 Illegal state encoding -> IDLE on the next edge.

Reset
REQ-032 rst asserted at any time, including mid-level or mid-pause, SHALL immediately force IDLE.
REQ-033 rst SHALL force outputs: level=1, time_left=FRAME_LIMIT, playing=0, frame_tick=0, game_over=0, game_won=0.
REQ-034 rst SHALL clear the pause counter and the v_sync edge-detect register to 0.
REQ-035 First rising edge of clk after rst deassertion performs normal IDLE evaluation.

Structure
REQ-036 State encodings, MAX_LEVEL default and counter widths SHALL live in shared package game_pkg.
REQ-037 v_sync edge detection SHALL be sub-module vsync_edge (clk, rst, v_sync_in -> frame_tick).
REQ-038 Everything else SHALL stay in game_level_ctrl, single clock domain, no latches.

Verification (FRAME_LIMIT=10, PAUSE_FRAMES=3, MAX_LEVEL=9 for bench)
REQ-039 Reset then start -> playing=1, level=1, time_left=10; after 10 frame_ticks -> game_over=1, time_left=0.
REQ-040 PLAY level 1, level_done -> level=2, playing=0; after 3 frame_ticks -> playing=1, time_left=10.
REQ-041 level_done at level 9 -> game_won=1, level=9; start -> level=1, playing=1.
REQ-042 fail and level_done in the same cycle at level 4 -> game_over=1, level=4.
REQ-043 rst mid-PAUSE at level 5 -> outputs at reset values immediately, before the next clk edge.
REQ-044 v_sync_in held high for 50 cycles -> exactly one frame_tick; start during PLAY -> no change.
